// File: rtl/spi_host.sv
// spi_host: Z80 I/O-mapped SPI host controller.
// Sits upstream of the byte-wide SPI shift engine: drives its ce/io/d inputs,
// captures its q output, and exposes data, control and status registers plus
// an auto-read port that launches 0xFF transfers for block reads.
module spi_host #(
    parameter int unsigned SLOW_DIV = 35,  // clocks per spi_ce pulse in slow mode (2..255)
    parameter int unsigned NCS      = 2    // number of active-low chip selects (1..4)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [1:0]     a,
    input  logic           wr,
    input  logic           rd,
    input  logic [7:0]     d,
    output logic [7:0]     q,
    output logic           busy,
    output logic [NCS-1:0] cs_n,
    output logic           spi_ce,
    output logic           spi_io,
    output logic [7:0]     spi_d,
    input  logic [7:0]     spi_q
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        SHIFT,
        SETTLE
    } state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(SLOW_DIV - 1);
    localparam logic [4:0] TICKS_PER_BYTE = 5'd16;

    state_t     state;
    logic       slow;       // mode as last written by the CPU
    logic       slow_eff;   // mode the CE generator is actually running
    logic [7:0] div;
    logic [4:0] tick;
    logic [7:0] rx;
    logic       overrun;

    logic       start_req;
    logic       start_is_data;
    logic       rd_status;
    logic [7:0] ctrl_rd;

    // Transfer starts come from a data write (a=0) or an auto-read (a=3).
    assign start_is_data = wr && (a == 2'd0);
    assign start_req     = start_is_data || (rd && (a == 2'd3));
    assign rd_status     = rd && (a == 2'd2);

    // Control register read-back: slow in bit 7, chip selects in the low bits.
    always_comb begin
        ctrl_rd          = '0;
        ctrl_rd[NCS-1:0] = cs_n;
        ctrl_rd[7]       = slow;
    end

    // Control register: chip selects and requested bit-rate mode, writable any time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs_n <= '1;
            slow <= 1'b1;
        end else if (wr && (a == 2'd1)) begin
            cs_n <= d[NCS-1:0];
            slow <= d[7];
        end
    end

    // CE generator; a requested mode change is only applied while idle so a
    // byte in flight keeps a constant bit rate, and it restarts the divider.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slow_eff <= 1'b1;
            div      <= DIV_RELOAD;
            spi_ce   <= 1'b0;
        end else if ((state == IDLE) && (slow_eff != slow)) begin
            slow_eff <= slow;
            div      <= DIV_RELOAD;
            spi_ce   <= !slow;
        end else if (!slow_eff) begin
            spi_ce <= 1'b1;
        end else if (div == 8'd0) begin
            div    <= DIV_RELOAD;
            spi_ce <= 1'b1;
        end else begin
            div    <= div - 8'd1;
            spi_ce <= 1'b0;
        end
    end

    // Transfer FSM with CPU read port and overrun tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            spi_io  <= 1'b0;
            spi_d   <= 8'hFF;
            rx      <= 8'hFF;
            q       <= '0;
            overrun <= 1'b0;
            tick    <= '0;
        end else begin
            if (rd) begin
                case (a)
                    2'd0:    q <= rx;
                    2'd1:    q <= ctrl_rd;
                    2'd2:    q <= {6'b0, overrun, busy};
                    default: q <= rx;
                endcase
            end

            // Set is written last so it wins over a same-edge status clear.
            if (rd_status) begin
                overrun <= 1'b0;
            end
            if (start_req && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_req) begin
                        spi_d  <= start_is_data ? d : 8'hFF;
                        busy   <= 1'b1;
                        spi_io <= 1'b1;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (spi_ce) begin
                        tick   <= '0;
                        spi_io <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick == TICKS_PER_BYTE) begin
                        state <= SETTLE;
                    end else if (spi_ce) begin
                        tick <= tick + 5'd1;
                    end
                end
                SETTLE: begin
                    rx    <= spi_q;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
